// File: rtl/uart_mvm_pkg.sv
// Shared constants and operand/result typedefs for the UART-fed
// 2x2 signed matrix-vector multiplier.
package uart_mvm_pkg;

    localparam int DEF_CLOCKS_PER_PULSE = 2604;
    localparam int BITS_PER_WORD        = 8;
    localparam int PACKET_SIZE_TX       = 13;
    localparam int R                    = 2;
    localparam int C                    = 2;
    localparam int W_X                  = 4;
    localparam int W_K                  = 2;
    localparam int W_Y_OUT              = 8;

    localparam int W_Y        = W_X + W_K + $clog2(C);
    localparam int W_BUS_KX   = R * C * W_K + C * W_X;
    localparam int W_BUS_Y    = R * W_Y_OUT;
    localparam int N_WORDS_KX = W_BUS_KX / BITS_PER_WORD;
    localparam int N_WORDS_Y  = W_BUS_Y / BITS_PER_WORD;

    typedef logic [C-1:0][W_X-1:0]          x_vec_t;
    typedef logic [R-1:0][C-1:0][W_K-1:0]   k_mat_t;
    typedef logic [R-1:0][W_Y_OUT-1:0]      y_vec_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic {
        TX_IDLE,
        TX_SEND
    } tx_state_t;

endpackage

// File: rtl/uart_mvm_sys_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling,
// glitch rejection on the start bit and silent drop on framing error.
module uart_rx
    import uart_mvm_pkg::*;
#(
    parameter int CLOCKS_PER_PULSE = DEF_CLOCKS_PER_PULSE
) (
    input  logic                     clk,
    input  logic                     i_rst,
    input  logic                     i_rx,
    output logic [BITS_PER_WORD-1:0] o_data,
    output logic                     o_valid
);

    localparam int HALF = CLOCKS_PER_PULSE / 2;

    rx_state_t                r_state;
    logic [1:0]               r_sync;
    logic                     r_prev;
    logic [15:0]              r_cnt;
    logic [2:0]               r_bit;
    logic [BITS_PER_WORD-1:0] r_data;
    logic                     r_valid;
    logic                     w_rx;

    assign w_rx    = r_sync[1];
    assign o_data  = r_data;
    assign o_valid = r_valid;

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_state <= RX_IDLE;
            r_sync  <= 2'b11;
            r_prev  <= 1'b1;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_rx};
            r_prev  <= w_rx;
            r_valid <= 1'b0;
            case (r_state)
                RX_IDLE: begin
                    r_cnt <= '0;
                    if (r_prev && !w_rx)
                        r_state <= RX_START;
                end
                RX_START: begin
                    if (r_cnt == 16'(HALF - 1)) begin
                        r_cnt   <= '0;
                        r_bit   <= '0;
                        // line back high at mid start bit means it was a glitch
                        r_state <= w_rx ? RX_IDLE : RX_DATA;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                RX_DATA: begin
                    if (r_cnt == 16'(CLOCKS_PER_PULSE - 1)) begin
                        r_cnt  <= '0;
                        r_data <= {w_rx, r_data[BITS_PER_WORD-1:1]};
                        if (r_bit == 3'(BITS_PER_WORD - 1))
                            r_state <= RX_STOP;
                        else
                            r_bit <= r_bit + 3'd1;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                RX_STOP: begin
                    if (r_cnt == 16'(CLOCKS_PER_PULSE - 1)) begin
                        r_cnt   <= '0;
                        r_valid <= w_rx;
                        r_state <= RX_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                default: r_state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_mvm_sys.sv
// TinyTapeout-style top: assembles KX frames from UART bytes, computes
// Y = K*X, buffers one result and serializes it back over UART.
module uart_mvm_sys
    import uart_mvm_pkg::*;
#(
    parameter int CLOCKS_PER_PULSE = DEF_CLOCKS_PER_PULSE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int N_STOP = PACKET_SIZE_TX - BITS_PER_WORD - 1;

    logic [BITS_PER_WORD-1:0]  w_rx_byte;
    logic                      w_rx_valid;
    logic [W_BUS_KX-1:0]       r_kx_bus;
    logic [3:0]                r_byte_cnt;
    logic                      r_kx_valid;
    x_vec_t                    w_x;
    k_mat_t                    w_k;
    y_vec_t                    w_y;
    logic signed [W_Y-1:0]     w_acc;
    y_vec_t                    r_y;
    logic                      r_y_full;
    tx_state_t                 r_tx_state;
    logic [W_BUS_Y-1:0]        r_ybuf;
    logic [PACKET_SIZE_TX-1:0] r_frame;
    logic [15:0]               r_clk_cnt;
    logic [3:0]                r_bit_cnt;
    logic [3:0]                r_word_cnt;
    logic                      r_tx;
    logic                      w_unused;

    assign w_unused = &{1'b0, ena, uio_in, ui_in[7:1]};
    assign uo_out   = {7'b0, r_tx};
    assign uio_out  = '0;
    assign uio_oe   = '0;

    uart_rx #(
        .CLOCKS_PER_PULSE(CLOCKS_PER_PULSE)
    ) u_rx (
        .clk    (clk),
        .i_rst  (rst),
        .i_rx   (ui_in[0]),
        .o_data (w_rx_byte),
        .o_valid(w_rx_valid)
    );

    // shifting in from the top leaves the first byte in the low bits
    always_ff @(posedge clk) begin
        if (rst) begin
            r_kx_bus   <= '0;
            r_byte_cnt <= '0;
            r_kx_valid <= 1'b0;
        end else begin
            r_kx_valid <= 1'b0;
            if (w_rx_valid) begin
                r_kx_bus <= {w_rx_byte, r_kx_bus[W_BUS_KX-1:BITS_PER_WORD]};
                if (r_byte_cnt == 4'(N_WORDS_KX - 1)) begin
                    r_byte_cnt <= '0;
                    r_kx_valid <= 1'b1;
                end else begin
                    r_byte_cnt <= r_byte_cnt + 4'd1;
                end
            end
        end
    end

    assign w_x = r_kx_bus[C*W_X-1:0];
    assign w_k = r_kx_bus[W_BUS_KX-1:C*W_X];

    always_comb begin
        w_y   = '0;
        w_acc = '0;
        for (int r = 0; r < R; r++) begin
            w_acc = '0;
            for (int c = 0; c < C; c++)
                w_acc = w_acc + W_Y'($signed(w_k[r][c])) * W_Y'($signed(w_x[c]));
            w_y[r] = W_Y_OUT'(w_acc);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_y        <= '0;
            r_y_full   <= 1'b0;
            r_tx_state <= TX_IDLE;
            r_ybuf     <= '0;
            r_frame    <= '1;
            r_clk_cnt  <= '0;
            r_bit_cnt  <= '0;
            r_word_cnt <= '0;
            r_tx       <= 1'b1;
        end else begin
            case (r_tx_state)
                TX_IDLE: begin
                    r_tx <= 1'b1;
                    if (r_y_full) begin
                        r_ybuf     <= r_y;
                        r_frame    <= {{N_STOP{1'b1}}, r_y[0], 1'b0};
                        r_tx       <= 1'b0;
                        r_clk_cnt  <= '0;
                        r_bit_cnt  <= '0;
                        r_word_cnt <= '0;
                        r_y_full   <= 1'b0;
                        r_tx_state <= TX_SEND;
                    end
                end
                TX_SEND: begin
                    if (r_clk_cnt == 16'(CLOCKS_PER_PULSE - 1)) begin
                        r_clk_cnt <= '0;
                        if (r_bit_cnt != 4'(PACKET_SIZE_TX - 1)) begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                            r_frame   <= r_frame >> 1;
                            r_tx      <= r_frame[1];
                        end else if (r_word_cnt == 4'(N_WORDS_Y - 1)) begin
                            r_tx       <= 1'b1;
                            r_tx_state <= TX_IDLE;
                        end else begin
                            r_word_cnt <= r_word_cnt + 4'd1;
                            r_bit_cnt  <= '0;
                            r_ybuf     <= r_ybuf >> W_Y_OUT;
                            r_frame    <= {{N_STOP{1'b1}},
                                           r_ybuf[W_Y_OUT +: W_Y_OUT], 1'b0};
                            r_tx       <= 1'b0;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 16'd1;
                    end
                end
                default: r_tx_state <= TX_IDLE;
            endcase
            // a result arriving while the buffer is occupied is dropped
            if (r_kx_valid && !r_y_full) begin
                r_y      <= w_y;
                r_y_full <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_mvm_sys.sv
// Directed bench for uart_mvm_sys: drives UART frames on ui_in[0] and
// decodes the tx line into words compared against hand-computed values.
module tb_uart_mvm_sys;

    localparam int CPP = 208;

    logic       clk;
    logic       rst;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_checks;
    int n_errors;

    logic [7:0] q_word[$];
    logic       q_ok[$];

    logic [7:0] v_b0[3]  = '{8'h21, 8'h88, 8'h77};
    logic [7:0] v_b1[3]  = '{8'h6D, 8'hAA, 8'hAA};
    logic [7:0] v_y0[3]  = '{8'hFF, 8'h20, 8'hE4};
    logic [7:0] v_y1[3]  = '{8'h00, 8'h20, 8'hE4};

    uart_mvm_sys #(
        .CLOCKS_PER_PULSE(CPP)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .ena    (ena),
        .ui_in  (ui_in),
        .uo_out (uo_out),
        .uio_in (uio_in),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // tx line decoder: start, 8 data LSB first, 4 stop bits
    initial begin : monitor
        logic [7:0] w;
        logic       ok;
        forever begin
            @(negedge uo_out[0]);
            repeat (CPP / 2) @(posedge clk);
            #1;
            ok = (uo_out[0] === 1'b0);
            for (int i = 0; i < 8; i++) begin
                repeat (CPP) @(posedge clk);
                #1;
                w[i] = uo_out[0];
            end
            for (int i = 0; i < 4; i++) begin
                repeat (CPP) @(posedge clk);
                #1;
                if (uo_out[0] !== 1'b1) ok = 1'b0;
            end
            q_word.push_back(w);
            q_ok.push_back(ok);
        end
    end

    function automatic logic [7:0] model_y(input logic [15:0] bus, input int r);
        int               acc;
        logic signed [3:0] xv;
        logic signed [1:0] kv;
        acc = 0;
        for (int c = 0; c < 2; c++) begin
            xv  = bus[c*4 +: 4];
            kv  = bus[8 + (r*2 + c)*2 +: 2];
            acc = acc + int'(kv) * int'(xv);
        end
        return acc[7:0];
    endfunction

    task automatic send_byte(input logic [7:0] b, input logic stop);
        ui_in[0] = 1'b0;
        repeat (CPP) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            ui_in[0] = b[i];
            repeat (CPP) @(negedge clk);
        end
        ui_in[0] = stop;
        repeat (CPP) @(negedge clk);
        ui_in[0] = 1'b1;
    endtask

    task automatic wait_words(input int n, output logic to);
        to = 1'b1;
        for (int i = 0; i < 60 * CPP; i++) begin
            if (q_word.size() >= n) begin
                to = 1'b0;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst      = 1'b1;
        ui_in    = 8'h01;
        uio_in   = 8'h00;
        ena      = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (uo_out !== 8'h01) begin
            n_errors++;
            $display("FAIL reset_uo_out: got %h want 01", uo_out);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            repeat (CPP) @(negedge clk);
            n_checks++;
            if (uo_out !== 8'h01 || uio_oe !== 8'h00 || uio_out !== 8'h00) begin
                n_errors++;
                $display("FAIL reset_idle: uo_out=%h uio_oe=%h uio_out=%h want 01 00 00",
                         uo_out, uio_oe, uio_out);
            end
        end
    endtask

    task automatic test_directed;
        logic to;
        for (int v = 0; v < 3; v++) begin
            q_word.delete();
            q_ok.delete();
            send_byte(v_b0[v], 1'b1);
            send_byte(v_b1[v], 1'b1);
            wait_words(2, to);
            n_checks++;
            if (to) begin
                n_errors++;
                $display("FAIL directed%0d_timeout: got %0d words want 2", v, q_word.size());
            end else begin
                n_checks += 3;
                if (q_word[0] !== v_y0[v]) begin
                    n_errors++;
                    $display("FAIL directed%0d_y0: got %h want %h", v, q_word[0], v_y0[v]);
                end
                if (q_word[1] !== v_y1[v]) begin
                    n_errors++;
                    $display("FAIL directed%0d_y1: got %h want %h", v, q_word[1], v_y1[v]);
                end
                if (q_ok[0] !== 1'b1 || q_ok[1] !== 1'b1) begin
                    n_errors++;
                    $display("FAIL directed%0d_framing: got %b%b want 11", v, q_ok[0], q_ok[1]);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] bus_a;
        logic [15:0] bus_b;
        logic [7:0]  exp[4];
        int          gap;
        logic        to;
        q_word.delete();
        q_ok.delete();
        bus_a  = 16'($urandom);
        bus_b  = 16'($urandom);
        gap    = int'($urandom_range(1, 100));
        exp[0] = model_y(bus_a, 0);
        exp[1] = model_y(bus_a, 1);
        exp[2] = model_y(bus_b, 0);
        exp[3] = model_y(bus_b, 1);
        send_byte(bus_a[7:0], 1'b1);
        send_byte(bus_a[15:8], 1'b1);
        repeat (gap) @(negedge clk);
        send_byte(bus_b[7:0], 1'b1);
        send_byte(bus_b[15:8], 1'b1);
        wait_words(4, to);
        n_checks++;
        if (to) begin
            n_errors++;
            $display("FAIL b2b_timeout: got %0d words want 4", q_word.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (q_word[i] !== exp[i] || q_ok[i] !== 1'b1) begin
                    n_errors++;
                    $display("FAIL b2b_word%0d: got %h stop_ok=%b want %h stop_ok=1",
                             i, q_word[i], q_ok[i], exp[i]);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_glitch_framing;
        logic to;
        q_word.delete();
        q_ok.delete();
        ui_in[0] = 1'b0;
        repeat (100) @(negedge clk);
        ui_in[0] = 1'b1;
        repeat (2 * CPP) @(negedge clk);
        send_byte(8'h55, 1'b0);
        repeat (2 * CPP) @(negedge clk);
        n_checks++;
        if (q_word.size() != 0) begin
            n_errors++;
            $display("FAIL glitch_no_tx: got %0d words want 0", q_word.size());
        end
        send_byte(8'h21, 1'b1);
        send_byte(8'h6D, 1'b1);
        wait_words(2, to);
        n_checks++;
        if (to) begin
            n_errors++;
            $display("FAIL glitch_timeout: got %0d words want 2", q_word.size());
        end else begin
            n_checks += 2;
            if (q_word[0] !== 8'hFF) begin
                n_errors++;
                $display("FAIL glitch_y0: got %h want ff", q_word[0]);
            end
            if (q_word[1] !== 8'h00) begin
                n_errors++;
                $display("FAIL glitch_y1: got %h want 00", q_word[1]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_tx;
        logic seen;
        logic stayed;
        send_byte(8'h21, 1'b1);
        send_byte(8'h6D, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 10 * CPP; i++) begin
            if (uo_out[0] === 1'b0) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        n_checks++;
        if (!seen) begin
            n_errors++;
            $display("FAIL midrst_start: tx never went low, want a start bit");
        end
        repeat (3 * CPP) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (uo_out !== 8'h01) begin
            n_errors++;
            $display("FAIL midrst_tx: got %h want 01", uo_out);
        end
        @(negedge clk);
        rst    = 1'b0;
        stayed = 1'b1;
        for (int i = 0; i < 14 * CPP; i++) begin
            @(negedge clk);
            if (uo_out[0] !== 1'b1) stayed = 1'b0;
        end
        n_checks++;
        if (!stayed) begin
            n_errors++;
            $display("FAIL midrst_idle: tx left idle after reset, want constant 1");
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_glitch_framing();
        test_reset_mid_tx();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_mvm_sys.md
Name: uart_mvm_sys

Overview:
UART-fed signed matrix-vector multiplier, packaged as a TinyTapeout-style top level.
- Receives one packed operand frame (2x2 weight matrix K plus 2-element vector X) as 8N1 UART bytes on one pin.
- Computes Y = K·X.
- Returns the R results as UART words on one output pin.
- Sits directly behind the chip pads; the host PC is the only peer.

Parameters:
CLOCKS_PER_PULSE, 2604, clock cycles per UART bit (50 MHz / 19200 baud), shared by RX and TX.
BITS_PER_WORD, 8, data bits per UART word.
PACKET_SIZE_TX, 13, TX frame length in bits: 1 start + 8 data + 4 stop (idle-high).
R, 2, matrix rows (number of outputs).
C, 2, matrix columns (vector length).
W_X, 4, signed width of each X element.
W_K, 2, signed width of each K element.
W_Y_OUT, 8, transmitted width of each Y element.

Ports:
clk  in  1  single system clock.
rst  in  1  synchronous reset, active-high.
ena  in  1  always 1 when powered; ignored.
ui_in  in  8  bit 0 = UART rx (idle high); bits 7:1 unused.
uo_out  out  8  bit 0 = UART tx (idle high); bits 7:1 driven 0.
uio_in  in  8  unused.
uio_out  out  8  driven 0.
uio_oe  out  8  driven 0 (all inputs).

Behaviour:
- Reset state: tx=1; all FSMs idle; buffers empty; uio_out, uio_oe and uo_out[7:1] are 0 at all times.
- RX path:
  - rx passes through a 2-flop synchronizer.
  - Falling edge in IDLE starts a frame; rx is re-checked low at half a bit. If high, the edge is a glitch and RX returns to IDLE.
  - Data bits are sampled every CLOCKS_PER_PULSE at mid-bit, LSB first, then the stop bit.
  - Stop bit = 0 is a framing error: the byte is discarded and the word counter is unchanged.
- Frame assembly:
  - N_WORDS_KX = (R*C*W_K + C*W_X)/8 = 2 bytes make one KX bus; the first received byte forms bits [7:0].
  - X occupies the low C*W_X bits: x[c] = bus[c*W_X +: W_X].
  - K occupies the bits above: k[r][c] = bus[C*W_X + (r*C+c)*W_K +: W_K].
  - After the last byte, the KX register is marked valid and the byte counter wraps to 0.
- MVM:
  - y[r] = sum over c of signed(k[r][c]) * signed(x[c]).
  - Internal width is W_Y = W_X + W_K + clog2(C) = 7, sign-extended to W_Y_OUT.
  - Result registered 1 clk after KX valid, into a one-entry result buffer.
- TX path:
  - When the serializer is idle and the result buffer is full, it copies all R*W_Y_OUT bits and frees the buffer in the same cycle.
  - It sends y[0] first, then y[1]. Each word is start 0, 8 data bits LSB first, then 4 high bits, each bit CLOCKS_PER_PULSE cycles long.
  - Words are sent back to back; tx returns to 1 when done.
- Concurrency:
  - RX never stalls; a new frame may arrive while TX is busy.
  - If a KX frame completes while the result buffer is still full, the new result is dropped. No error output exists.
- Reset mid-operation: all partial bytes, frames and TX words are abandoned; tx is forced to 1 on the next clock.

Decomposition:
- Package uart_mvm_pkg holds the parameter defaults and the derived constants W_Y, W_BUS_KX, W_BUS_Y, N_WORDS_KX and N_WORDS_Y.
- It also holds packed typedefs for the x vector, k matrix and y vector.
- Sub-module uart_rx (synchronizer + deserializer producing a byte plus a 1-cycle valid) is natural.
- The top holds frame assembly, the MVM, the result buffer and the TX serializer.

Test Plan:
- Reset held 2 clk then released, rx idle -> tx stays 1, uo_out[7:1]=0, uio_oe=0.
- RX 0x21 then 0x6D (x0=1, x1=2; k00=1, k01=-1, k10=-2, k11=1) -> TX 0xFF then 0x00, each with 4 high stop bits.
- RX 0x88 then 0xAA (x=-8,-8; all k=-2) -> TX 0x20, 0x20.
- RX 0x77 then 0xAA -> TX 0xE4, 0xE4.
- Two random frames, second starting 1–100 clk after the first ends (overlapping TX) -> both results transmitted in order and match a software model.
- Glitch of 100 clk low on rx, and a byte with stop bit 0 -> no byte counted; the next valid 2-byte frame produces the correct result.
